// File: rtl/code_conv_pkg.sv
// Shared types and constants for the arbitrated binary/Gray code converter.
package code_conv_pkg;

  localparam int unsigned CONV_W = 16;

  localparam logic DIR_B2G = 1'b0;
  localparam logic DIR_G2B = 1'b1;

  typedef enum logic [1:0] {IDLE, LOAD, CONV, ACK} state_e;

endpackage

// File: rtl/code_conv_arb_if.sv
// Request/acknowledge bundle between two requesters and the converter arbiter.
interface code_conv_arb_if #(
  parameter int unsigned W = 16
);
  logic         req0;
  logic         dir0;
  logic [W-1:0] din0;
  logic         req1;
  logic         dir1;
  logic [W-1:0] din1;
  logic         ack0;
  logic         ack1;
  logic [W-1:0] dout;
  logic         busy;

  modport master (
    output req0, dir0, din0, req1, dir1, din1,
    input  ack0, ack1, dout, busy
  );

  modport slave (
    input  req0, dir0, din0, req1, dir1, din1,
    output ack0, ack1, dout, busy
  );
endinterface

// File: rtl/code_conv.sv
// Combinational binary<->Gray converter; the single shared datapath.
module code_conv
  import code_conv_pkg::*;
#(
  parameter int unsigned W = CONV_W
) (
  input  logic [W-1:0] operand,
  input  logic         dir,
  output logic [W-1:0] result
);

  always_comb begin
    result = operand ^ (operand >> 1);
    if (dir == DIR_G2B) begin
      // Each binary bit is the XOR of the Gray bits from the MSB down to it.
      for (int i = 0; i < W; i++) begin
        result[i] = ^(operand >> i);
      end
    end
  end

endmodule

// File: rtl/code_conv_arb.sv
// Round-robin arbiter and 4-state sequencer in front of one shared code_conv.
module code_conv_arb
  import code_conv_pkg::*;
#(
  parameter int unsigned W = CONV_W
) (
  input logic            clk,
  input logic            rst,
  code_conv_arb_if.slave bus
);

  state_e       state_q, state_d;
  logic         last_q;
  logic         win_q;
  logic         dir_q;
  logic [W-1:0] op_q;
  logic [W-1:0] dout_q;
  logic [W-1:0] conv_res;
  logic         grant;

  code_conv #(
    .W(W)
  ) u_conv (
    .operand(op_q),
    .dir    (dir_q),
    .result (conv_res)
  );

  always_comb begin
    state_d = state_q;
    // On contention the port that did not win last time goes next.
    if (bus.req0 && bus.req1) begin
      grant = ~last_q;
    end else begin
      grant = bus.req1;
    end
    unique case (state_q)
      IDLE: if (bus.req0 || bus.req1) state_d = LOAD;
      LOAD: state_d = CONV;
      CONV: state_d = ACK;
      ACK:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      dir_q   <= 1'b0;
      op_q    <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == LOAD) begin
        win_q  <= grant;
        last_q <= grant;
        dir_q  <= grant ? bus.dir1 : bus.dir0;
        op_q   <= grant ? bus.din1 : bus.din0;
      end
      if (state_q == CONV) begin
        dout_q <= conv_res;
      end
    end
  end

  assign bus.ack0 = (state_q == ACK) && !win_q;
  assign bus.ack1 = (state_q == ACK) && win_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.dout = dout_q;

endmodule

// File: tb/tb_code_conv_arb.sv
// Scoreboard bench for code_conv_arb: latency, arbitration, withdrawal and reset abort.
module tb_code_conv_arb;

  typedef struct packed {
    logic        port;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  code_conv_arb_if #(.W(16)) bus ();

  code_conv_arb #(.W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [15:0] b2g_m(input logic [15:0] b);
    return b ^ {1'b0, b[15:1]};
  endfunction

  function automatic logic [15:0] g2b_m(input logic [15:0] g);
    logic [15:0] x;
    x = g;
    x = x ^ (x >> 1);
    x = x ^ (x >> 2);
    x = x ^ (x >> 4);
    x = x ^ (x >> 8);
    return x;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.req0 = 1'b0; bus.dir0 = 1'b0; bus.din0 = '0;
    bus.req1 = 1'b0; bus.dir1 = 1'b0; bus.din1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Bounded wait for an ack; reports cycles elapsed, busy cycles and what was seen.
  task automatic wait_ack(output int cyc, output int busy_n, output logic p0, output logic p1,
                          output logic [15:0] d);
    cyc = 0; busy_n = 0; p0 = 1'b0; p1 = 1'b0; d = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_n++;
      if (bus.ack0 || bus.ack1) begin
        p0 = bus.ack0; p1 = bus.ack1; d = bus.dout;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.ack0 !== 1'b0) begin bad++; $display("FAIL reset_ack0 got=%b want=0", bus.ack0); end
    total++; if (bus.ack1 !== 1'b0) begin bad++; $display("FAIL reset_ack1 got=%b want=0", bus.ack1); end
    total++; if (bus.dout !== 16'h0) begin bad++; $display("FAIL reset_dout got=%h want=0000", bus.dout); end
  endtask

  task automatic test_single();
    int cyc, bn; logic p0, p1; logic [15:0] d; exp_t e;
    bus.req0 = 1'b1; bus.dir0 = 1'b0; bus.din0 = 16'h1234;
    sb.push_back('{port: 1'b0, data: 16'h1B2E});
    wait_ack(cyc, bn, p0, p1, d);
    bus.req0 = 1'b0;
    total++; if (p0 !== 1'b1 || p1 !== 1'b0) begin bad++; $display("FAIL single_acks got=%b%b want=10", p0, p1); end
    total++; if (cyc != 3) begin bad++; $display("FAIL single_latency got=%0d want=3", cyc); end
    total++; if (bn != 3) begin bad++; $display("FAIL single_busy got=%0d want=3", bn); end
    e = sb.pop_front();
    total++; if (d !== e.data) begin bad++; $display("FAIL single_dout got=%h want=%h", d, e.data); end
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_g2b();
    logic [15:0] ins [2];
    int cyc, bn; logic p0, p1; logic [15:0] d; exp_t e;
    ins[0] = 16'h0080; ins[1] = 16'h8000;
    for (int t = 0; t < 2; t++) begin
      bus.req1 = 1'b1; bus.dir1 = 1'b1; bus.din1 = ins[t];
      sb.push_back('{port: 1'b1, data: (t == 0) ? 16'h00FF : 16'hFFFF});
      wait_ack(cyc, bn, p0, p1, d);
      bus.req1 = 1'b0;
      e = sb.pop_front();
      total++; if (p1 !== 1'b1 || p0 !== 1'b0) begin bad++; $display("FAIL g2b_acks[%0d] got=%b%b want=01", t, p1, p0); end
      total++; if (d !== e.data) begin bad++; $display("FAIL g2b_dout[%0d] got=%h want=%h", t, d, e.data); end
      @(negedge clk);
    end
  endtask

  task automatic test_simul();
    int cyc, bn; logic p0, p1; logic [15:0] d; exp_t e;
    do_reset();
    bus.req0 = 1'b1; bus.dir0 = 1'b0; bus.din0 = 16'hFFFF;
    bus.req1 = 1'b1; bus.dir1 = 1'b1; bus.din1 = 16'h8000;
    sb.push_back('{port: 1'b0, data: 16'h8000});
    sb.push_back('{port: 1'b1, data: 16'hFFFF});
    for (int t = 0; t < 2; t++) begin
      wait_ack(cyc, bn, p0, p1, d);
      if (p0) bus.req0 = 1'b0;
      if (p1) bus.req1 = 1'b0;
      e = sb.pop_front();
      total++; if (p1 !== e.port || (p0 | p1) !== 1'b1) begin bad++; $display("FAIL simul_port[%0d] got=%b%b want_port=%b", t, p0, p1, e.port); end
      total++; if (d !== e.data) begin bad++; $display("FAIL simul_dout[%0d] got=%h want=%h", t, d, e.data); end
      total++; if (cyc != 3 + t) begin bad++; $display("FAIL simul_latency[%0d] got=%0d want=%0d", t, cyc, 3 + t); end
    end
    @(negedge clk);
  endtask

  task automatic test_contention();
    int n0, n1, gap0, gap1; exp_t e;
    logic [15:0] a, b;
    do_reset();
    a = 16'($urandom); b = 16'($urandom);
    bus.req0 = 1'b1; bus.dir0 = 1'b0; bus.din0 = a;
    bus.req1 = 1'b1; bus.dir1 = 1'b1; bus.din1 = b;
    for (int t = 0; t < 8; t++) begin
      sb.push_back('{port: t[0], data: t[0] ? g2b_m(b) : b2g_m(a)});
    end
    n0 = 0; n1 = 0; gap0 = -1; gap1 = -1;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (bus.ack0 && bus.ack1) begin
        total++; bad++; $display("FAIL cont_overlap cycle=%0d got=11 want=not both", c);
      end else if (bus.ack0 || bus.ack1) begin
        if (sb.size() == 0) begin
          total++; bad++; $display("FAIL cont_extra_ack cycle=%0d got=ack want=none", c);
        end else begin
          e = sb.pop_front();
          total++; if (bus.ack1 !== e.port) begin bad++; $display("FAIL cont_port cycle=%0d got=%b want=%b", c, bus.ack1, e.port); end
          total++; if (bus.dout !== e.data) begin bad++; $display("FAIL cont_dout cycle=%0d got=%h want=%h", c, bus.dout, e.data); end
        end
        if (bus.ack0) begin
          if (gap0 >= 0) begin total++; if (c - gap0 != 8) begin bad++; $display("FAIL cont_gap0 got=%0d want=8", c - gap0); end end
          gap0 = c; n0++;
        end else begin
          if (gap1 >= 0) begin total++; if (c - gap1 != 8) begin bad++; $display("FAIL cont_gap1 got=%0d want=8", c - gap1); end end
          gap1 = c; n1++;
        end
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    total++; if (n0 != 4 || n1 != 4) begin bad++; $display("FAIL cont_counts got=%0d/%0d want=4/4", n0, n1); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL cont_left got=%0d want=0", sb.size()); sb.delete(); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_withdraw();
    int cyc, bn; logic p0, p1; logic [15:0] d; exp_t e;
    bus.req0 = 1'b1; bus.dir0 = 1'b0; bus.din0 = 16'h00F0;
    sb.push_back('{port: 1'b0, data: b2g_m(16'h00F0)});
    @(negedge clk);
    bus.req0 = 1'b0; bus.din0 = 16'hFFFF; bus.dir0 = 1'b1;
    wait_ack(cyc, bn, p0, p1, d);
    e = sb.pop_front();
    total++; if (p0 !== 1'b1 || p1 !== 1'b0) begin bad++; $display("FAIL withdraw_acks got=%b%b want=10", p0, p1); end
    total++; if (d !== e.data) begin bad++; $display("FAIL withdraw_dout got=%h want=%h", d, e.data); end
    total++; if (cyc != 2) begin bad++; $display("FAIL withdraw_latency got=%0d want=2", cyc); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc, bn, acks; logic p0, p1; logic [15:0] d; exp_t e;
    bus.req0 = 1'b1; bus.dir0 = 1'b0; bus.din0 = 16'h1234;
    @(negedge clk);
    bus.req0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_in_conv got=%b want=1", bus.busy); end
    @(negedge clk);
    rst = 1'b0;
    total++; if (bus.dout !== 16'h0) begin bad++; $display("FAIL mid_dout got=%h want=0000", bus.dout); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", bus.busy); end
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.ack0 || bus.ack1) acks++;
      @(negedge clk);
    end
    total++; if (acks != 0) begin bad++; $display("FAIL mid_no_ack got=%0d want=0", acks); end
    bus.req1 = 1'b1; bus.dir1 = 1'b1; bus.din1 = 16'h0080;
    sb.push_back('{port: 1'b1, data: 16'h00FF});
    wait_ack(cyc, bn, p0, p1, d);
    bus.req1 = 1'b0;
    e = sb.pop_front();
    total++; if (p1 !== 1'b1 || p0 !== 1'b0) begin bad++; $display("FAIL mid_req1_acks got=%b%b want=01", p1, p0); end
    total++; if (d !== e.data) begin bad++; $display("FAIL mid_req1_dout got=%h want=%h", d, e.data); end
    total++; if (cyc != 3) begin bad++; $display("FAIL mid_req1_latency got=%0d want=3", cyc); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_g2b();
    test_simul();
    test_contention();
    test_withdraw();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
